// File: rtl/axis_gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD from raw GMII receive data and
// presents the frame (FCS intact) as an 8-bit AXI4-Stream. The GMII side
// cannot be stalled, so a blocked output drops the rest of the frame and
// closes it with a tuser-marked tlast beat.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   gmii_rxd/_dv/_er  GMII receive data, data valid, receive error
//   m_axis_*          AXI4-Stream master (tdata, tvalid, tready, tlast, tuser)
//                     tuser marks a bad frame and is meaningful on tlast only
//   busy              registered, high while the next state is not IDLE
//   error_*           single-cycle status pulses (bad_frame, framing,
//                     overflow, length)
module axis_gmii_rx_deframer #(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy,
  output logic       error_bad_frame,
  output logic       error_framing,
  output logic       error_overflow,
  output logic       error_length
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP,
    WAIT_END
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  rxd_d0;
  logic        dv_d0;
  logic        er_d0;

  logic [7:0]  hold_data;
  logic        hold_valid;
  logic [15:0] len;
  logic        sticky_er;

  logic        out_free;
  logic        len_bad;

  // Input register stage; every decision below is made on these values.
  always_ff @(posedge clk) begin
    rxd_d0 <= gmii_rxd;
    dv_d0  <= gmii_rx_dv;
    er_d0  <= gmii_rx_er;
  end

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign len_bad  = (len < MIN_LEN) || (len > MAX_LEN);

  // Next-state decode kept separate so busy can be registered from it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dv_d0 && rxd_d0 == 8'h55) state_next = PREAMBLE;
      end
      PREAMBLE: begin
        if (!dv_d0)                state_next = IDLE;
        else if (rxd_d0 == 8'hD5)  state_next = PAYLOAD;
        else if (rxd_d0 != 8'h55)  state_next = WAIT_END;
      end
      PAYLOAD: begin
        // Any emit that finds the output register blocked aborts the frame.
        if (hold_valid && !out_free) state_next = DROP;
        else if (!dv_d0)             state_next = IDLE;
      end
      DROP: begin
        if (out_free) state_next = dv_d0 ? WAIT_END : IDLE;
      end
      WAIT_END: begin
        if (!dv_d0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WAIT_END;
      busy            <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      hold_valid      <= 1'b0;
      sticky_er       <= 1'b0;
      len             <= '0;
      error_bad_frame <= 1'b0;
      error_framing   <= 1'b0;
      error_overflow  <= 1'b0;
      error_length    <= 1'b0;
    end else begin
      state           <= state_next;
      busy            <= (state_next != IDLE);
      error_bad_frame <= 1'b0;
      error_framing   <= 1'b0;
      error_overflow  <= 1'b0;
      error_length    <= 1'b0;

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        PREAMBLE: begin
          if (dv_d0) begin
            if (rxd_d0 == 8'hD5) begin
              hold_valid <= 1'b0;
              len        <= '0;
              sticky_er  <= 1'b0;
            end else if (rxd_d0 != 8'h55) begin
              error_framing <= 1'b1;
            end
          end
        end

        PAYLOAD: begin
          if (dv_d0) begin
            if (hold_valid && !out_free) begin
              // Incoming byte is discarded; hold keeps the last good byte
              // so DROP can close the frame with it.
              error_overflow <= 1'b1;
            end else begin
              if (hold_valid) begin
                m_axis_tdata  <= hold_data;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= 1'b0;
              end
              hold_data  <= rxd_d0;
              hold_valid <= 1'b1;
              len        <= (len == '1) ? len : len + 16'd1;
              sticky_er  <= sticky_er | er_d0;
            end
          end else begin
            if (!hold_valid) begin
              // SFD followed directly by end of carrier: nothing to emit.
              error_framing <= 1'b1;
            end else if (!out_free) begin
              error_overflow <= 1'b1;
            end else begin
              m_axis_tdata    <= hold_data;
              m_axis_tvalid   <= 1'b1;
              m_axis_tlast    <= 1'b1;
              m_axis_tuser    <= sticky_er | len_bad;
              hold_valid      <= 1'b0;
              error_bad_frame <= sticky_er;
              error_length    <= len_bad;
            end
          end
        end

        DROP: begin
          if (out_free) begin
            m_axis_tdata  <= hold_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= 1'b1;
            hold_valid    <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_gmii_rx_deframer.sv
// Scoreboard bench for axis_gmii_rx_deframer: expected beats are queued as
// each frame is driven and compared as beats are accepted on m_axis.
module tb_axis_gmii_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gmii_rxd = '0;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       busy;
  logic       error_bad_frame;
  logic       error_framing;
  logic       error_overflow;
  logic       error_length;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  int unsigned cyc = 0;
  int unsigned cnt_bad = 0, cnt_framing = 0, cnt_ovf = 0, cnt_len = 0;
  int unsigned beats_seen = 0;
  int unsigned first_cyc = 0, drive0_cyc = 0;
  bit          mon_en = 1'b0;
  bit          got_first = 1'b0;

  axis_gmii_rx_deframer #(
    .MIN_FRAME_LEN(64),
    .MAX_FRAME_LEN(1518)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .busy           (busy),
    .error_bad_frame(error_bad_frame),
    .error_framing  (error_framing),
    .error_overflow (error_overflow),
    .error_length   (error_length)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic last, input logic user);
    beat_t b;
    b.data = 8'(k);
    b.last = last;
    b.user = user;
    exp_q.push_back(b);
  endtask

  // Monitor: counts status pulses and compares accepted beats.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (error_bad_frame) begin
          cnt_bad++;
          check("bad_frame_on_tlast", {30'd0, m_axis_tvalid, m_axis_tlast}, 32'd3);
        end
        if (error_framing)  cnt_framing++;
        if (error_overflow) cnt_ovf++;
        if (error_length)   cnt_len++;
        if (m_axis_tvalid && !got_first) begin
          got_first = 1'b1;
          first_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("extra_beat", {24'd0, m_axis_tdata}, 32'h100);
          end else begin
            e = exp_q.pop_front();
            check("data", {24'd0, m_axis_tdata}, {24'd0, e.data});
            check("last", {31'd0, m_axis_tlast}, {31'd0, e.last});
            if (e.last) check("user", {31'd0, m_axis_tuser}, {31'd0, e.user});
          end
        end
      end
    end
  end

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  // npre x 0x55, then sfd, then len data bytes (value = index).
  // er_idx: byte carrying rx_er; rst_at: byte during which rst is pulsed;
  // cut: index of the closing beat when the output is stalled mid-frame.
  task automatic send_frame(input int npre, input logic [7:0] sfd, input int len,
                            input int er_idx, input int rst_at, input int cut);
    logic user;
    user = (er_idx >= 0 && er_idx < len) || (len < 64) || (len > 1518);
    if (sfd == 8'hD5 && len > 0) begin
      if (rst_at >= 0)   for (int k = 0; k <= rst_at - 3; k++) push(k, 1'b0, 1'b0);
      else if (cut >= 0) for (int k = 0; k <= cut; k++) push(k, k == cut, 1'b1);
      else               for (int k = 0; k < len; k++) push(k, k == len - 1, user);
    end
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, sfd, 1'b0);
    for (int k = 0; k < len; k++) begin
      drive(1'b1, 8'(k), k == er_idx);
      rst = (k == rst_at);
      if (k == 0) begin
        drive0_cyc = cyc;
        got_first  = 1'b0;
      end
      if (sfd == 8'hD5 && k == 10) check("busy_payload", {31'd0, busy}, 32'd1);
      if (rst_at >= 0 && k == rst_at + 1) check("rst_tvalid_mid", {31'd0, m_axis_tvalid}, 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic end_frame(input string tag, input int eb, input int ef, input int eo, input int el);
    check({tag, "_bad_pulses"}, cnt_bad, eb);
    check({tag, "_framing_pulses"}, cnt_framing, ef);
    check({tag, "_overflow_pulses"}, cnt_ovf, eo);
    check({tag, "_length_pulses"}, cnt_len, el);
    check({tag, "_pending_beats"}, exp_q.size(), 0);
    exp_q.delete();
    cnt_bad = 0; cnt_framing = 0; cnt_ovf = 0; cnt_len = 0;
    beats_seen = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_errors", {28'd0, error_bad_frame, error_framing, error_overflow, error_length}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(4);

    // Good minimum-length frame, with first-beat latency.
    send_frame(7, 8'hD5, 64, -1, -1, -1);
    idle(6);
    check("first_beat_latency", first_cyc - drive0_cyc, 32'd3);
    end_frame("good64", 0, 0, 0, 0);

    // rx_er inside payload.
    send_frame(7, 8'hD5, 64, 10, -1, -1);
    idle(6);
    end_frame("rx_er", 1, 0, 0, 0);

    // Length boundaries.
    send_frame(7, 8'hD5, 20, -1, -1, -1);
    idle(6);
    end_frame("runt20", 0, 0, 0, 1);
    send_frame(7, 8'hD5, 1519, -1, -1, -1);
    idle(6);
    end_frame("over1519", 0, 0, 0, 1);
    send_frame(7, 8'hD5, 1518, -1, -1, -1);
    idle(6);
    end_frame("max1518", 0, 0, 0, 0);

    // Bad SFD, then a clean frame.
    send_frame(2, 8'h5D, 30, -1, -1, -1);
    idle(4);
    check("busy_after_bad_pre", {31'd0, busy}, 32'd0);
    end_frame("bad_pre", 0, 1, 0, 0);
    send_frame(7, 8'hD5, 64, -1, -1, -1);
    idle(6);
    end_frame("after_bad_pre", 0, 0, 0, 0);

    // SFD with no data.
    send_frame(7, 8'hD5, 0, -1, -1, -1);
    idle(4);
    end_frame("empty", 0, 1, 0, 0);

    // Output stalled for 4 cycles while beat 5 is presented: beats 0..5
    // go out, byte 6 (held) closes the frame with tuser.
    fork
      send_frame(7, 8'hD5, 64, -1, -1, 6);
      begin
        int unsigned t = 0;
        while (beats_seen < 5 && t < 300) begin
          @(posedge clk);
          t++;
        end
        check("ovf_stall_start", beats_seen, 32'd5);
        #1;
        m_axis_tready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
      end
    join
    idle(6);
    end_frame("overflow", 0, 0, 1, 0);

    // Back-to-back frames with a single idle cycle.
    send_frame(7, 8'hD5, 64, -1, -1, -1);
    idle(1);
    send_frame(7, 8'hD5, 70, -1, -1, -1);
    idle(6);
    end_frame("back2back", 0, 0, 0, 0);

    // Reset mid-payload, then a frame after one idle cycle.
    send_frame(7, 8'hD5, 64, -1, 20, -1);
    idle(1);
    send_frame(7, 8'hD5, 64, -1, -1, -1);
    idle(6);
    end_frame("mid_reset", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
